// File: rtl/pe_pkg.sv
// ============================================================================
// Module      : pe_pkg
// Description : Shared command encodings, field-select bit positions and FSM
//               state type for the mac_shift_cell processing element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    typedef enum logic [2:0] {
        CMD_MAC     = 3'b000,
        CMD_UP      = 3'b001,
        CMD_DOWN    = 3'b010,
        CMD_LEFT    = 3'b011,
        CMD_RIGHT   = 3'b100,
        CMD_LOAD_AB = 3'b101,
        CMD_LOAD_S  = 3'b110,
        CMD_CLEAR   = 3'b111
    } cmd_e;

    localparam int SEL_A = 0;
    localparam int SEL_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pe_mul_pipe.sv
// ============================================================================
// Module      : pe_mul_pipe
// Description : Free-running signed multiplier with MUL_STAGES output registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mul_pipe #(
    parameter int PRECISION  = 8,
    parameter int MUL_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic signed [PRECISION-1:0]   a_i,
    input  logic signed [PRECISION-1:0]   b_i,
    output logic signed [2*PRECISION-1:0] p_o
);

    logic signed [2*PRECISION-1:0] w_a_ext;
    logic signed [2*PRECISION-1:0] w_b_ext;
    logic signed [2*PRECISION-1:0] stage_q [MUL_STAGES];

    // Full-width sign extension keeps the truncated product exact.
    assign w_a_ext = {{PRECISION{a_i[PRECISION-1]}}, a_i};
    assign w_b_ext = {{PRECISION{b_i[PRECISION-1]}}, b_i};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= w_a_ext * w_b_ext;
            for (int i = 1; i < MUL_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign p_o = stage_q[MUL_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mac_shift_cell.sv
// ============================================================================
// Module      : mac_shift_cell
// Description : Systolic PE: neighbour shifts, operand loads and a pipelined
//               signed multiply-accumulate with optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_shift_cell
    import pe_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32,
    parameter int MUL_STAGES       = 2,
    parameter int SATURATE         = 0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd,
    input  logic [1:0]                    sel,
    output logic                          done,
    input  logic [2*PRECISION-1:0]        isu,
    input  logic [2*PRECISION-1:0]        isd,
    input  logic [2*PRECISION-1:0]        isl,
    input  logic [2*PRECISION-1:0]        isr,
    output logic [2*PRECISION-1:0]        osu,
    output logic [2*PRECISION-1:0]        osd,
    output logic [2*PRECISION-1:0]        osl,
    output logic [2*PRECISION-1:0]        osr,
    input  logic [PRECISION-1:0]          a_overwrite,
    input  logic [PRECISION-1:0]          b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0]   s_out_overwrite,
    output logic [PRECISION-1:0]          A,
    output logic [PRECISION-1:0]          B,
    output logic [OUTPUT_PRECISION-1:0]   s_out,
    output logic                          ovf
);

    localparam int                        c_P       = PRECISION;
    localparam int                        c_OP      = OUTPUT_PRECISION;
    localparam logic [2:0]                c_CNT_END = 3'(MUL_STAGES - 1);
    localparam logic [c_OP-1:0]           c_SAT_MAX = {1'b0, {(c_OP-1){1'b1}}};
    localparam logic [c_OP-1:0]           c_SAT_MIN = {1'b1, {(c_OP-1){1'b0}}};

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [c_P-1:0]        a_q, a_d, b_q, b_d;
    logic [c_OP-1:0]       s_q, s_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic [2*c_P-1:0]      os_q [4];
    logic [2*c_P-1:0]      os_d [4];

    logic [2*c_P-1:0]      w_is [4];
    logic [1:0]            w_dir;
    logic                  w_accept;
    logic signed [2*c_P-1:0] w_prod;
    logic signed [c_OP-1:0]  w_prod_ext;
    logic [c_OP-1:0]       w_sum;
    logic                  w_ovf;
    logic [c_OP-1:0]       w_acc;

    pe_mul_pipe #(
        .PRECISION  (PRECISION),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .CLK   (CLK),
        .reset (reset),
        .a_i   (a_q),
        .b_i   (b_q),
        .p_o   (w_prod)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Direction index 0..3 = up, down, left, right (shift codes 1..4).
    assign w_dir   = 2'(cmd - 3'd1);
    assign w_is[0] = isu;
    assign w_is[1] = isd;
    assign w_is[2] = isl;
    assign w_is[3] = isr;

    assign w_prod_ext = c_OP'(w_prod);
    assign w_sum      = s_q + w_prod_ext;
    assign w_ovf      = (s_q[c_OP-1] == w_prod_ext[c_OP-1]) && (w_sum[c_OP-1] != s_q[c_OP-1]);
    assign w_acc      = (SATURATE != 0 && w_ovf) ? (s_q[c_OP-1] ? c_SAT_MIN : c_SAT_MAX) : w_sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        os_d    = os_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    done_d = 1'b1;
                    case (cmd)
                        CMD_MAC: begin
                            done_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end
                        CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT: begin
                            os_d[w_dir] = {b_q, a_q};
                            if (sel[SEL_A]) a_d = w_is[w_dir][c_P-1:0];
                            if (sel[SEL_B]) b_d = w_is[w_dir][2*c_P-1:c_P];
                        end
                        CMD_LOAD_AB: begin
                            if (sel[SEL_A]) a_d = a_overwrite;
                            if (sel[SEL_B]) b_d = b_overwrite;
                        end
                        CMD_LOAD_S: s_d = s_out_overwrite;
                        CMD_CLEAR: begin
                            a_d   = '0;
                            b_d   = '0;
                            s_d   = '0;
                            ovf_d = 1'b0;
                            for (int i = 0; i < 4; i++) os_d[i] = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == c_CNT_END) state_d = ST_ACC;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            ST_ACC: begin
                s_d     = w_acc;
                ovf_d   = ovf_q | w_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) os_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            for (int i = 0; i < 4; i++) os_q[i] <= os_d[i];
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign s_out = s_q;
    assign ovf   = ovf_q;
    assign done  = done_q;
    assign osu   = os_q[0];
    assign osd   = os_q[1];
    assign osl   = os_q[2];
    assign osr   = os_q[3];

endmodule

`default_nettype wire

// File: tb/tb_mac_shift_cell.sv
// ============================================================================
// Module      : tb_mac_shift_cell
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized commands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mac_shift_cell;

    localparam logic [2:0] C_MAC = 3'd0, C_UP = 3'd1, C_DOWN = 3'd2, C_LEFT = 3'd3;
    localparam logic [2:0] C_RIGHT = 3'd4, C_LDAB = 3'd5, C_LDS = 3'd6, C_CLR = 3'd7;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] isu = '0, isd = '0, isl = '0, isr = '0;
    logic [7:0]  a_ow = '0, b_ow = '0;
    logic [31:0] s_ow = '0;

    logic        cmd_ready, done, ovf;
    logic [15:0] osu, osd, osl, osr;
    logic [7:0]  A, B;
    logic [31:0] s_out;

    logic        sat_ready, sat_done, sat_ovf, wr_ready, wr_done, wr_ovf;
    logic [15:0] sat_osu, sat_osd, sat_osl, sat_osr, wr_osu, wr_osd, wr_osl, wr_osr;
    logic [7:0]  sat_a, sat_b, wr_a, wr_b;
    logic [15:0] sat_s, wr_s;

    mac_shift_cell u_dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .sel(sel), .done(done),
        .isu(isu), .isd(isd), .isl(isl), .isr(isr),
        .osu(osu), .osd(osd), .osl(osl), .osr(osr),
        .a_overwrite(a_ow), .b_overwrite(b_ow), .s_out_overwrite(s_ow),
        .A(A), .B(B), .s_out(s_out), .ovf(ovf)
    );

    mac_shift_cell #(.OUTPUT_PRECISION(16), .SATURATE(1)) u_sat (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(sat_ready),
        .cmd(cmd), .sel(sel), .done(sat_done),
        .isu(isu), .isd(isd), .isl(isl), .isr(isr),
        .osu(sat_osu), .osd(sat_osd), .osl(sat_osl), .osr(sat_osr),
        .a_overwrite(a_ow), .b_overwrite(b_ow), .s_out_overwrite(s_ow[15:0]),
        .A(sat_a), .B(sat_b), .s_out(sat_s), .ovf(sat_ovf)
    );

    mac_shift_cell #(.OUTPUT_PRECISION(16), .SATURATE(0)) u_wrap (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(wr_ready),
        .cmd(cmd), .sel(sel), .done(wr_done),
        .isu(isu), .isd(isd), .isl(isl), .isr(isr),
        .osu(wr_osu), .osd(wr_osd), .osl(wr_osl), .osr(wr_osr),
        .a_overwrite(a_ow), .b_overwrite(b_ow), .s_out_overwrite(s_ow[15:0]),
        .A(wr_a), .B(wr_b), .s_out(wr_s), .ovf(wr_ovf)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer a command, wait (bounded) for acceptance, then count edges to done.
    task automatic issue(input logic [2:0] c, input logic [1:0] s, output int lat);
        int w;
        w = 0;
        cmd = c;
        sel = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [1:0]  s;
        logic [15:0] din;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] sow;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [31:0] es;
        int          elat;
    } vec_t;

    vec_t tbl [8];

    // Reference model state
    logic [7:0]  m_a, m_b;
    logic [31:0] m_s;
    logic        m_ovf;
    logic [15:0] m_os [4];
    logic [15:0] m_is [4];

    initial begin : main
        int          lat, elat, hold_n, d;
        logic [7:0]  a0, b0;
        logic [15:0] u0, prev, ra;
        longint      sum;

        tbl[0] = '{C_CLR,   2'b00, 16'h0000, 8'h00, 8'h00, 32'h0,        8'h00, 8'h00, 32'h00000000, 0};
        tbl[1] = '{C_LDAB,  2'b11, 16'h0000, 8'h03, 8'hFC, 32'h0,        8'h03, 8'hFC, 32'h00000000, 0};
        tbl[2] = '{C_MAC,   2'b00, 16'h0000, 8'h00, 8'h00, 32'h0,        8'h03, 8'hFC, 32'hFFFFFFF4, 3};
        tbl[3] = '{C_MAC,   2'b00, 16'h0000, 8'h00, 8'h00, 32'h0,        8'h03, 8'hFC, 32'hFFFFFFE8, 3};
        tbl[4] = '{C_LDAB,  2'b11, 16'h0000, 8'h11, 8'h22, 32'h0,        8'h11, 8'h22, 32'hFFFFFFE8, 0};
        tbl[5] = '{C_LEFT,  2'b01, 16'hBBAA, 8'h00, 8'h00, 32'h0,        8'hAA, 8'h22, 32'hFFFFFFE8, 0};
        tbl[6] = '{C_LDS,   2'b00, 16'h0000, 8'h00, 8'h00, 32'h12345678, 8'hAA, 8'h22, 32'h12345678, 0};
        tbl[7] = '{C_RIGHT, 2'b10, 16'h5A00, 8'h00, 8'h00, 32'h0,        8'hAA, 8'h5A, 32'h12345678, 0};

        // Reset state
        #1;
        step();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ab", {16'h0, A, B}, 32'h0);
        chk("rst_s", s_out, 32'h0);
        chk("rst_os", {osu, osd}, 32'h0);
        chk("rst_os2", {osl, osr}, 32'h0);
        chk("rst_flags", {30'h0, ovf, done}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            isu = tbl[i].din; isd = tbl[i].din; isl = tbl[i].din; isr = tbl[i].din;
            a_ow = tbl[i].a; b_ow = tbl[i].b; s_ow = tbl[i].sow;
            issue(tbl[i].c, tbl[i].s, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
            chk($sformatf("vec%0d_A", i), 32'(A), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_B", i), 32'(B), 32'(tbl[i].eb));
            chk($sformatf("vec%0d_s", i), s_out, tbl[i].es);
        end
        chk("vec_osl", 32'(osl), 32'h2211);
        chk("vec_osr", 32'(osr), 32'h22AA);
        chk("vec_osu_osd", {osu, osd}, 32'h0);
        chk("vec_ovf", 32'(ovf), 32'd0);

        // Saturating vs wrapping 16-bit accumulators
        do_reset();
        s_ow = 32'h00007FF0;
        issue(C_LDS, 2'b00, lat);
        a_ow = 8'd16; b_ow = 8'd16;
        issue(C_LDAB, 2'b11, lat);
        issue(C_MAC, 2'b00, lat);
        chk("sat_lat", 32'(lat), 32'd3);
        chk("sat_s", 32'(sat_s), 32'h7FFF);
        chk("sat_ovf", 32'(sat_ovf), 32'd1);
        chk("wrap_s", 32'(wr_s), 32'h80F0);
        chk("wrap_ovf", 32'(wr_ovf), 32'd1);
        s_ow = 32'h0;
        issue(C_LDS, 2'b00, lat);
        chk("wrap_ovf_sticky", 32'(wr_ovf), 32'd1);
        chk("wrap_s_loaded", 32'(wr_s), 32'h0);
        issue(C_CLR, 2'b00, lat);
        chk("wrap_ovf_cleared", 32'(wr_ovf), 32'd0);

        // Shift-up held during a MAC is ignored until cmd_ready rises
        a_ow = 8'h5C; b_ow = 8'hE7;
        issue(C_LDAB, 2'b11, lat);
        a0 = A; b0 = B; u0 = osu;
        cmd = C_MAC; sel = 2'b00; cmd_valid = 1'b1;
        step();
        cmd = C_UP; sel = 2'b11; isu = 16'hC3D4;
        hold_n = 0;
        while (!cmd_ready && hold_n < 10) begin
            chk("hold_A", 32'(A), 32'(a0));
            chk("hold_B", 32'(B), 32'(b0));
            chk("hold_osu", 32'(osu), 32'(u0));
            step();
            hold_n++;
        end
        chk("hold_cycles", 32'(hold_n), 32'd3);
        chk("hold_mac_done", 32'(done), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("held_up_A", 32'(A), 32'hD4);
        chk("held_up_B", 32'(B), 32'hC3);
        chk("held_up_osu", 32'(osu), {16'h0, b0, a0});
        chk("held_up_done", 32'(done), 32'd1);
        isu = 16'h1122;
        step();
        chk("held_up_once_osu", 32'(osu), {16'h0, b0, a0});
        chk("held_up_once_A", 32'(A), 32'hD4);
        chk("held_up_once_done", 32'(done), 32'd0);

        // Reset one cycle after a MAC accept
        cmd = C_MAC; sel = 2'b00; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("abort_ab", {16'h0, A, B}, 32'h0);
        chk("abort_s", s_out, 32'h0);
        chk("abort_os", {osu, osd}, 32'h0);
        chk("abort_os2", {osl, osr}, 32'h0);
        chk("abort_flags", {29'h0, ovf, done, cmd_ready}, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_s_hold", s_out, 32'h0);
        end

        // Four back-to-back right shifts on B only
        cmd = C_RIGHT; sel = 2'b10; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            isr = ra;
            prev = {B, A};
            step();
            chk($sformatf("b2b%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("b2b%0d_B", i), 32'(B), 32'(ra[15:8]));
            chk($sformatf("b2b%0d_A", i), 32'(A), 32'd0);
            chk($sformatf("b2b%0d_osr", i), 32'(osr), 32'(prev));
        end
        cmd_valid = 1'b0;
        step();
        chk("b2b_done_end", 32'(done), 32'd0);

        // Randomized commands against the reference model
        do_reset();
        m_a = '0; m_b = '0; m_s = '0; m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) m_os[i] = '0;
        for (int it = 0; it < 300; it++) begin
            logic [2:0] c;
            logic [1:0] s;
            c = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) m_is[k] = 16'($urandom);
            isu = m_is[0]; isd = m_is[1]; isl = m_is[2]; isr = m_is[3];
            a_ow = 8'($urandom); b_ow = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       s_ow = 32'h7FFF0000 | 32'($urandom_range(0, 65535));
                1:       s_ow = 32'h80000000 | 32'($urandom_range(0, 65535));
                default: s_ow = $urandom;
            endcase
            elat = 0;
            if (c == C_MAC) begin
                elat = 3;
                sum = longint'($signed(m_s)) + longint'($signed(m_a)) * longint'($signed(m_b));
                if (sum > 64'sd2147483647 || sum < -64'sd2147483648) m_ovf = 1'b1;
                m_s = sum[31:0];
            end else if (c >= C_UP && c <= C_RIGHT) begin
                d = int'(c) - 1;
                m_os[d] = {m_b, m_a};
                if (s[0]) m_a = m_is[d][7:0];
                if (s[1]) m_b = m_is[d][15:8];
            end else if (c == C_LDAB) begin
                if (s[0]) m_a = a_ow;
                if (s[1]) m_b = b_ow;
            end else if (c == C_LDS) begin
                m_s = s_ow;
            end else begin
                m_a = '0; m_b = '0; m_s = '0; m_ovf = 1'b0;
                for (int k = 0; k < 4; k++) m_os[k] = '0;
            end
            issue(c, s, lat);
            chk($sformatf("rnd%0d_c%0d_lat", it, c), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_c%0d_A", it, c), 32'(A), 32'(m_a));
            chk($sformatf("rnd%0d_c%0d_B", it, c), 32'(B), 32'(m_b));
            chk($sformatf("rnd%0d_c%0d_s", it, c), s_out, m_s);
            chk($sformatf("rnd%0d_c%0d_ovf", it, c), 32'(ovf), 32'(m_ovf));
            chk($sformatf("rnd%0d_c%0d_osu_osd", it, c), {osu, osd}, {m_os[0], m_os[1]});
            chk($sformatf("rnd%0d_c%0d_osl_osr", it, c), {osl, osr}, {m_os[2], m_os[3]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
